// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver FSM states, PS/2 prefix codes and the queued key-event layout.
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } event_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: key-event FIFO; drops on full unless a pop frees a slot, head held while empty.
module ps2_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             overflow
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] hold;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count;
   logic full, wr, rd;
   assign valid = count != '0;
   assign full = count == (AW+1)'(DEPTH);
   assign rd = pop && valid;
   assign wr = push && (!full || rd);
   assign dout = valid ? mem[rptr] : hold;
   always_ff @(posedge clk)
      if (wr) mem[wptr] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         hold <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
         if (valid) hold <= mem[rptr];
         overflow <= push && full && !rd;
      end
endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 frame decoder folding E0/F0 prefixes into queued key events.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2clk,
   input  logic       data,
   output logic [7:0] keycode,
   output logic       extended,
   output logic       released,
   output logic       valid,
   input  logic       ready,
   output logic       idle,
   output logic       frame_err,
   output logic       overflow
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif
   logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
   logic clk_prev, fall, din, par, byte_done, pend_ext, pend_brk, timeout, stop_ok, push;
   logic [7:0] shreg;
   logic [2:0] bitcnt;
   logic [TW-1:0] tocnt;
   state_t state, state_nx;
   event_t ev_in, ev_out;
   assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign din = dat_sync[SYNC_STAGES-1];
   assign idle = state == IDLE;
   assign timeout = !idle && tocnt == TW'(TIMEOUT_CYCLES);
   assign stop_ok = din && (!PAR_CHK || ^{shreg, par});
   // shreg stays untouched in IDLE, so it still holds the finished byte one cycle after STOP
   assign push = byte_done && shreg != BREAK_CODE && shreg != EXT_CODE;
   assign ev_in = '{ext: pend_ext, brk: pend_brk, code: shreg};
   assign keycode = ev_out.code;
   assign extended = ev_out.ext;
   assign released = ev_out.brk;
   always_comb begin
      state_nx = state;
      if (timeout) state_nx = IDLE;
      else if (fall)
         case (state)
            IDLE:    state_nx = din ? IDLE : DATA;
            DATA:    state_nx = bitcnt == 3'd7 ? PARITY : DATA;
            PARITY:  state_nx = STOP;
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
         state <= IDLE;
         shreg <= '0;
         bitcnt <= '0;
         par <= 1'b0;
         tocnt <= '0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         pend_ext <= 1'b0;
         pend_brk <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], data};
         clk_prev <= clk_sync[SYNC_STAGES-1];
         state <= state_nx;
         tocnt <= (fall || idle) ? '0 : tocnt + 1'b1;
         if (fall && state == IDLE) bitcnt <= '0;
         if (fall && state == DATA) begin
            shreg <= {din, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
         end
         if (fall && state == PARITY) par <= din;
         byte_done <= fall && state == STOP && stop_ok && !timeout;
         frame_err <= timeout || (fall && state == STOP && !stop_ok);
         if (timeout) begin
            shreg <= '0;
            bitcnt <= '0;
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
         end else if (byte_done) begin
            pend_brk <= shreg == BREAK_CODE ? 1'b1 : shreg == EXT_CODE ? pend_brk : 1'b0;
            pend_ext <= shreg == EXT_CODE ? 1'b1 : shreg == BREAK_CODE ? pend_ext : 1'b0;
         end
      end
   ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .din(ev_in),
      .pop(ready),
      .dout(ev_out),
      .valid(valid),
      .overflow(overflow)
   );
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed PS/2 frames with hand-computed key events and error pulses.
module tb_ps2_key_receiver;
   localparam int TO = 100;
   localparam int H = 10;
   logic clk = 1'b0, reset = 1'b1, ps2clk = 1'b1, data = 1'b1, ready = 1'b1;
   logic [7:0] keycode;
   logic extended, released, valid, idle, frame_err, overflow;
   int n_checks = 0, n_errors = 0, fe_cnt = 0, ov_cnt = 0, fe0;
   logic [9:0] evq [$];

   ps2_key_receiver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .ps2clk(ps2clk), .data(data), .keycode(keycode),
      .extended(extended), .released(released), .valid(valid), .ready(ready),
      .idle(idle), .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      #1;
      if (!reset && valid && ready) evq.push_back({extended, released, keycode});
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic frame_head(input logic [7:0] b, input bit bad_par, input int n);
      logic [10:0] bits;
      bits = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < n; i++) begin
         data = bits[i];
         repeat (H) @(negedge clk);
         ps2clk = 1'b0;
         repeat (H) @(negedge clk);
         ps2clk = 1'b1;
      end
      data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      frame_head(b, 1'b0, 11);
      repeat (2 * H) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_idle", idle, 1);
      check("rst_valid", valid, 0);
      check("rst_keycode", keycode, 8'h00);
      check("rst_ext", extended, 0);
      check("rst_rel", released, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // stop-edge to valid latency for a plain 1C make code
      frame_head(8'h1C, 1'b0, 10);
      repeat (H) @(negedge clk);
      ps2clk = 1'b0;
      repeat (3) @(negedge clk);
      check("lat_valid_early", valid, 0);
      @(negedge clk);
      check("lat_valid", valid, 1);
      check("lat_keycode", keycode, 8'h1C);
      check("lat_ext", extended, 0);
      check("lat_rel", released, 0);
      @(negedge clk);
      check("lat_valid_drop", valid, 0);
      check("hold_keycode", keycode, 8'h1C);
      ps2clk = 1'b1;
      repeat (2 * H) @(negedge clk);
      check("lat_count", evq.size(), 1);
      evq.delete();

      send(8'hF0); send(8'h1C);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("pfx_count", evq.size(), 2);
      if (evq.size() == 2) begin
         check("pfx_break", evq[0], 10'h11C);
         check("pfx_ext_break", evq[1], 10'h375);
      end
      evq.delete();

      fe0 = fe_cnt;
      frame_head(8'h1C, 1'b1, 11);
      repeat (2 * H) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
      check("par_ferr", fe_cnt - fe0, 1);
      check("par_events", evq.size(), 0);
`else
      check("par_ferr", fe_cnt - fe0, 0);
      check("par_events", evq.size(), 1);
      if (evq.size() == 1) check("par_code", evq[0], 10'h01C);
`endif
      evq.delete();

      ready = 1'b0;
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h2A);
      check("ovf_pulses", ov_cnt, 1);
      check("ovf_valid", valid, 1);
      check("ovf_head", keycode, 8'h1C);
      check("ovf_none_popped", evq.size(), 0);
      ready = 1'b1;
      repeat (10) @(negedge clk);
      check("drain_count", evq.size(), 4);
      if (evq.size() == 4) begin
         check("drain0", evq[0], 10'h01C);
         check("drain1", evq[1], 10'h032);
         check("drain2", evq[2], 10'h021);
         check("drain3", evq[3], 10'h023);
      end
      check("drain_valid", valid, 0);
      evq.delete();

      // pending break must not survive an aborted frame
      send(8'hF0);
      fe0 = fe_cnt;
      frame_head(8'h1C, 1'b0, 4);
      check("to_busy", idle, 0);
      repeat (TO + 20) @(negedge clk);
      check("to_ferr", fe_cnt - fe0, 1);
      check("to_idle", idle, 1);
      send(8'h1C);
      check("to_count", evq.size(), 1);
      if (evq.size() == 1) check("to_next", evq[0], 10'h01C);
      evq.delete();

      ready = 1'b0;
      send(8'h32);
      check("mid_pre_valid", valid, 1);
      frame_head(8'h1C, 1'b0, 6);
      reset = 1'b1;
      #1;
      check("mid_idle", idle, 1);
      check("mid_valid", valid, 0);
      check("mid_keycode", keycode, 8'h00);
      check("mid_ext", extended, 0);
      check("mid_rel", released, 0);
      check("mid_ferr", frame_err, 0);
      ps2clk = 1'b1;
      data = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      ready = 1'b1;
      repeat (12 * H) @(negedge clk);
      check("mid_no_event", evq.size(), 0);
      check("mid_valid_after", valid, 0);
      check("mid_idle_after", idle, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, key-event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a PS/2 falling edge before a frame is aborted.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on ps2clk/data (>=2).
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  system clock; reset  in  1  async active-high reset.
REQ-005 ps2clk  in  1  raw PS/2 clock, sampled in the clk domain, never used as a clock.
REQ-006 data  in  1  raw PS/2 data line.
REQ-007 keycode  out  8  scan code at the FIFO head.
REQ-008 extended  out  1  head event was prefixed by E0.
REQ-009 release  out  1  head event was prefixed by F0 (break).
REQ-010 valid  out  1  FIFO non-empty; keycode/extended/release meaningful.
REQ-011 ready  in  1  consumer accepts the head event when valid && ready.
REQ-012 idle  out  1  receiver FSM in IDLE.
REQ-013 frame_err  out  1  one-cycle pulse on start/parity/stop/timeout error.
REQ-014 overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-015 ps2clk and data SHALL pass through SYNC_STAGES flops; a falling edge is a synchronised 1->0 transition, one-cycle strobe.
REQ-016 FSM states IDLE, DATA, PARITY, STOP; transitions occur only on a falling-edge strobe or timeout.
REQ-017 IDLE: edge with data=0 -> DATA, bit counter=0; edge with data=1 is ignored, no error.
REQ-018 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture bit -> STOP.
REQ-020 STOP: data=1 and parity accepted -> byte complete; otherwise frame_err pulse, byte discarded; either way -> IDLE.
REQ-021 Parity SHALL be odd over the 8 data bits plus parity bit.
REQ-022 Timeout counter SHALL clear on every edge strobe and in IDLE; reaching TIMEOUT_CYCLES outside IDLE -> IDLE, frame_err pulse, partial byte and prefix flags cleared.
REQ-023 Completed byte F0 SHALL set pending-break flag, E0 SHALL set pending-extended flag; neither pushes an event.
REQ-024 Any other completed byte SHALL push {pending-extended, pending-break, byte} and clear both flags in the same cycle.
REQ-025 Push SHALL occur the cycle after the STOP edge strobe; valid rises the following cycle when the FIFO was empty (2 cycles after strobe).
REQ-026 Pop on valid && ready; next entry presented the following cycle.
REQ-027 Push when full without a simultaneous pop: event dropped, overflow pulse, FIFO contents unchanged.
REQ-028 Push and pop in the same cycle when full: both accepted, no overflow.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy uses log2(FIFO_DEPTH)+1 bits.
REQ-030 keycode/extended/release SHALL hold their last head values when valid=0.

Reset
REQ-031 reset SHALL asynchronously force: FSM IDLE, idle=1, FIFO empty, valid=0, keycode=0, extended=0, release=0, frame_err=0, overflow=0, prefix flags 0, counters 0, synchronisers to 1.
REQ-032 Reset mid-frame SHALL discard the partial byte; no event pushed after reset release from that frame.

Configuration
REQ-033 With PS2_PARITY_CHECK_EN defined, parity errors SHALL pulse frame_err and discard the byte.
REQ-034 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored; only start/stop/timeout errors are reported.

Structure
REQ-035 Shared package ps2_pkg SHALL hold the FSM state typedef, BREAK_CODE=8'hF0, EXT_CODE=8'hE0 and the 10-bit event typedef.
REQ-036 The FIFO SHALL be the sub-module ps2_event_fifo (parameter DEPTH, WIDTH=10).

Verification
REQ-037 Frame 1C (parity 0, stop 1), ready=1 -> valid 2 cycles after stop edge, keycode=1C, extended=0, release=0, one cycle.
REQ-038 Frames F0,1C -> one event keycode=1C, release=1; frames E0,F0,75 -> keycode=75, extended=1, release=1.
REQ-039 Frame 1C with parity 1, macro defined -> frame_err pulse, no event; macro undefined -> event 1C.
REQ-040 ready=0, FIFO_DEPTH=4, send 1C,32,21,23,2A -> four events held in order, overflow pulse on 2A; drain returns 1C,32,21,23.
REQ-041 Start bit + 3 data bits then ps2clk held high for TIMEOUT_CYCLES -> frame_err pulse, idle=1; next full frame 1C decodes correctly.
REQ-042 Assert reset after 5 data bits of frame 1C -> all outputs at reset values, no event after release.
